// File: rtl/trace_pkg.sv
// Shared definitions for the trace trigger controller.
// Holds the capture FSM state encoding and the counter width.
package trace_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_POSTTRIG = 2'd2,
        ST_DONE     = 2'd3
    } trace_state_e;

endpackage

// File: rtl/trace_trigger_ctrl.sv
// Trace trigger controller: captures samples into an external ring buffer
// around a trigger event, then lets software drain the buffer.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   sample_i/_valid_i      trace sample stream; trig_i qualified by valid
//   arm_i, stop_i          start / manually end a capture
//   posttrig_i             samples kept after the trigger (latched on arm)
//   rd_req_i               pop one sample; rd_data_o/rd_valid_o/rd_err_o
//   tb_*                   ring-buffer write/read/clear port
//   state_o, triggered_o, sample_cnt_o  status
module trace_trigger_ctrl
    import trace_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int BITDEPTH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [BITWIDTH-1:0] sample_i,
    input  logic                sample_valid_i,
    input  logic                trig_i,
    input  logic                arm_i,
    input  logic                stop_i,
    input  logic [15:0]         posttrig_i,
    input  logic                rd_req_i,
    output logic [BITWIDTH-1:0] rd_data_o,
    output logic                rd_valid_o,
    output logic                rd_err_o,
    output logic [BITWIDTH-1:0] tb_wport_o,
    output logic                tb_wenq_o,
    output logic                tb_rdeq_o,
    output logic                tb_clear_o,
    input  logic [BITWIDTH-1:0] tb_rport_i,
    input  logic                tb_full_i,
    input  logic                tb_empty_i,
    input  logic [BITDEPTH:0]   tb_count_i,
    output logic [1:0]          state_o,
    output logic                triggered_o,
    output logic [15:0]         sample_cnt_o
);

    trace_state_e        state_q, state_d;
    logic                triggered_q, triggered_d;
    logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]    posttrig_q, posttrig_d;
    logic [CNT_W-1:0]    remain_q, remain_d;
    logic                wenq_q, wenq_d;
    logic [BITWIDTH-1:0] wport_q, wport_d;
    logic                clear_q, clear_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_err_q, rd_err_d;
    logic [BITWIDTH-1:0] rd_data_q, rd_data_d;

    logic capturing;
    logic take;
    logic has_data;
    logic rd_ok;

    assign capturing = (state_q == ST_ARMED) || (state_q == ST_POSTTRIG);
    // arm and stop both drop a sample arriving in the same cycle
    assign take = capturing && sample_valid_i && !arm_i && !stop_i;

    // a full buffer is never empty, so full also vouches for data
    assign has_data = !tb_empty_i && (tb_full_i || (tb_count_i != '0));

    // reads only while idle/done and never against a pending write/clear
    assign rd_ok = rd_req_i && !capturing && has_data
                   && !wenq_q && !clear_q && !arm_i;

    always_comb begin
        state_d      = state_q;
        triggered_d  = triggered_q;
        sample_cnt_d = sample_cnt_q;
        posttrig_d   = posttrig_q;
        remain_d     = remain_q;
        wenq_d       = 1'b0;
        wport_d      = wport_q;
        clear_d      = 1'b0;
        rd_valid_d   = rd_ok;
        rd_err_d     = rd_req_i && !rd_ok;
        rd_data_d    = rd_ok ? tb_rport_i : rd_data_q;

        if (arm_i) begin
            state_d      = ST_ARMED;
            clear_d      = 1'b1;
            triggered_d  = 1'b0;
            sample_cnt_d = '0;
            posttrig_d   = posttrig_i;
            remain_d     = '0;
        end else if (stop_i && capturing) begin
            state_d = ST_DONE;
        end else if (take) begin
            wenq_d  = 1'b1;
            wport_d = sample_i;
            if (sample_cnt_q != '1) begin
                sample_cnt_d = sample_cnt_q + 16'd1;
            end
            unique case (state_q)
                ST_ARMED: begin
                    if (trig_i) begin
                        triggered_d = 1'b1;
                        if (posttrig_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d  = ST_POSTTRIG;
                            remain_d = posttrig_q;
                        end
                    end
                end
                ST_POSTTRIG: begin
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            triggered_q  <= 1'b0;
            sample_cnt_q <= '0;
            posttrig_q   <= '0;
            remain_q     <= '0;
            wenq_q       <= 1'b0;
            wport_q      <= '0;
            clear_q      <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            triggered_q  <= triggered_d;
            sample_cnt_q <= sample_cnt_d;
            posttrig_q   <= posttrig_d;
            remain_q     <= remain_d;
            wenq_q       <= wenq_d;
            wport_q      <= wport_d;
            clear_q      <= clear_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign tb_rdeq_o    = rd_ok;
    assign tb_wenq_o    = wenq_q;
    assign tb_wport_o   = wport_q;
    assign tb_clear_o   = clear_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_err_o     = rd_err_q;
    assign rd_data_o    = rd_data_q;
    assign state_o      = state_q;
    assign triggered_o  = triggered_q;
    assign sample_cnt_o = sample_cnt_q;

endmodule

// File: tb/tb_trace_trigger_ctrl.sv
// Bench for trace_trigger_ctrl with a behavioural overwrite ring buffer
// and a queue of expected read-back samples.
module tb_trace_trigger_ctrl;

    localparam int BW  = 8;
    localparam int BD  = 4;
    localparam int DEP = 1 << BD;

    logic          clk = 1'b0;
    logic          resetn;
    logic [BW-1:0] sample_i;
    logic          sample_valid_i;
    logic          trig_i;
    logic          arm_i;
    logic          stop_i;
    logic [15:0]   posttrig_i;
    logic          rd_req_i;
    logic [BW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          rd_err_o;
    logic [BW-1:0] tb_wport_o;
    logic          tb_wenq_o;
    logic          tb_rdeq_o;
    logic          tb_clear_o;
    logic [BW-1:0] tb_rport_i;
    logic          tb_full_i;
    logic          tb_empty_i;
    logic [BD:0]   tb_count_i;
    logic [1:0]    state_o;
    logic          triggered_o;
    logic [15:0]   sample_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [BW-1:0] exp_q[$];

    always #10 clk = ~clk;

    trace_trigger_ctrl #(.BITWIDTH(BW), .BITDEPTH(BD)) dut (
        .clk(clk), .resetn(resetn),
        .sample_i(sample_i), .sample_valid_i(sample_valid_i),
        .trig_i(trig_i), .arm_i(arm_i), .stop_i(stop_i),
        .posttrig_i(posttrig_i), .rd_req_i(rd_req_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .rd_err_o(rd_err_o), .tb_wport_o(tb_wport_o),
        .tb_wenq_o(tb_wenq_o), .tb_rdeq_o(tb_rdeq_o),
        .tb_clear_o(tb_clear_o), .tb_rport_i(tb_rport_i),
        .tb_full_i(tb_full_i), .tb_empty_i(tb_empty_i),
        .tb_count_i(tb_count_i), .state_o(state_o),
        .triggered_o(triggered_o), .sample_cnt_o(sample_cnt_o)
    );

    // ring buffer: overwrites oldest entry when full
    logic [BW-1:0] mem [DEP];
    logic [BD-1:0] wp, rp;
    logic [BD:0]   cnt;

    assign tb_rport_i = mem[rp];
    assign tb_count_i = cnt;
    assign tb_full_i  = (cnt == DEP[BD:0]);
    assign tb_empty_i = (cnt == '0);

    always @(posedge clk) begin
        if (!resetn || tb_clear_o) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (tb_wenq_o) begin
            mem[wp] <= tb_wport_o;
            wp      <= wp + 1'b1;
            if (cnt == DEP[BD:0]) rp <= rp + 1'b1;
            else cnt <= cnt + 1'b1;
        end else if (tb_rdeq_o) begin
            rp  <= rp + 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_trig", 32'(triggered_o), 0);
        chk("rst_cnt", 32'(sample_cnt_o), 0);
        chk("rst_wenq", 32'(tb_wenq_o), 0);
        chk("rst_clear", 32'(tb_clear_o), 0);
        chk("rst_rdv", 32'(rd_valid_o), 0);
        chk("rst_rderr", 32'(rd_err_o), 0);
        chk("rst_rdata", 32'(rd_data_o), 0);
        chk("rst_wport", 32'(tb_wport_o), 0);
    endtask

    task automatic arm(input logic [15:0] pt);
        arm_i      = 1'b1;
        posttrig_i = pt;
        exp_q.delete();
        cyc();
        arm_i = 1'b0;
        chk("arm_clear", 32'(tb_clear_o), 1);
        chk("arm_state", 32'(state_o), 1);
        chk("arm_cnt", 32'(sample_cnt_o), 0);
    endtask

    task automatic send(input logic [BW-1:0] s, input logic t,
                        input logic cap);
        sample_i       = s;
        sample_valid_i = 1'b1;
        trig_i         = t;
        if (cap) begin
            exp_q.push_back(s);
            if (exp_q.size() > DEP) void'(exp_q.pop_front());
        end
        cyc();
        sample_valid_i = 1'b0;
        trig_i         = 1'b0;
        chk("wenq", 32'(tb_wenq_o), 32'(cap));
        if (cap) chk("wport", 32'(tb_wport_o), 32'(s));
    endtask

    task automatic rd(input logic ok);
        logic [BW-1:0] e;
        rd_req_i = 1'b1;
        #1;
        chk("rdeq", 32'(tb_rdeq_o), 32'(ok));
        cyc();
        rd_req_i = 1'b0;
        if (ok) begin
            chk("rd_valid", 32'(rd_valid_o), 1);
            if (exp_q.size() == 0) begin
                chk("rd_sb_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(rd_data_o), 32'(e));
            end
        end else begin
            chk("rd_err", 32'(rd_err_o), 1);
            chk("rd_novalid", 32'(rd_valid_o), 0);
        end
    endtask

    initial begin
        resetn         = 1'b0;
        sample_i       = '0;
        sample_valid_i = 1'b0;
        trig_i         = 1'b0;
        arm_i          = 1'b0;
        stop_i         = 1'b0;
        posttrig_i     = '0;
        rd_req_i       = 1'b0;
        cyc();
        cyc();
        chk_reset();
        resetn = 1'b1;
        cyc();

        // pre-trigger, trigger, three post samples, one late sample
        arm(16'd3);
        for (int i = 1; i <= 5; i++) send(BW'(i), 1'b0, 1'b1);
        send(8'h06, 1'b1, 1'b1);
        chk("t1_trig", 32'(triggered_o), 1);
        chk("t1_post", 32'(state_o), 2);
        send(8'h07, 1'b0, 1'b1);
        send(8'h08, 1'b0, 1'b1);
        send(8'h09, 1'b0, 1'b1);
        chk("t1_done", 32'(state_o), 3);
        send(8'h0A, 1'b0, 1'b0);
        chk("t1_cnt", 32'(sample_cnt_o), 9);
        cyc();
        for (int i = 0; i < 9; i++) rd(1'b1);
        rd(1'b0);
        chk("t1_stay", 32'(state_o), 3);

        // overflow: buffer keeps the newest 16 samples
        arm(16'd2);
        for (int i = 0; i < 30; i++) send(BW'(i), 1'b0, 1'b1);
        send(8'd30, 1'b1, 1'b1);
        send(8'd31, 1'b0, 1'b1);
        send(8'd32, 1'b0, 1'b1);
        chk("t2_done", 32'(state_o), 3);
        chk("t2_cnt", 32'(sample_cnt_o), 33);
        cyc();
        chk("t2_first", 32'(exp_q[0]), 17);
        for (int i = 0; i < DEP; i++) rd(1'b1);
        rd(1'b0);

        // zero post-trigger samples
        arm(16'd0);
        send(8'hAA, 1'b1, 1'b1);
        chk("t3_done", 32'(state_o), 3);
        cyc();
        rd(1'b1);
        rd(1'b0);

        // manual stop drops the coincident sample
        arm(16'd5);
        for (int i = 0; i < 4; i++) send(BW'(8'h40 + i), 1'b0, 1'b1);
        rd(1'b0);
        stop_i         = 1'b1;
        sample_valid_i = 1'b1;
        sample_i       = 8'hEE;
        cyc();
        stop_i         = 1'b0;
        sample_valid_i = 1'b0;
        chk("t4_done", 32'(state_o), 3);
        chk("t4_trig", 32'(triggered_o), 0);
        chk("t4_wenq", 32'(tb_wenq_o), 0);
        for (int i = 0; i < 4; i++) rd(1'b1);
        rd(1'b0);

        // re-arm overrides a triggering sample in POSTTRIG
        arm(16'd1);
        send(8'h01, 1'b0, 1'b1);
        send(8'h02, 1'b1, 1'b1);
        chk("t5_post", 32'(state_o), 2);
        arm_i          = 1'b1;
        posttrig_i     = 16'd4;
        sample_valid_i = 1'b1;
        trig_i         = 1'b1;
        sample_i       = 8'h77;
        exp_q.delete();
        cyc();
        arm_i          = 1'b0;
        sample_valid_i = 1'b0;
        trig_i         = 1'b0;
        chk("t5_clear", 32'(tb_clear_o), 1);
        chk("t5_wenq", 32'(tb_wenq_o), 0);
        chk("t5_state", 32'(state_o), 1);
        chk("t5_trig", 32'(triggered_o), 0);

        // reset in the middle of POSTTRIG
        send(8'h03, 1'b1, 1'b1);
        chk("t6_post", 32'(state_o), 2);
        resetn         = 1'b0;
        sample_valid_i = 1'b1;
        sample_i       = 8'h55;
        cyc();
        sample_valid_i = 1'b0;
        chk_reset();
        resetn = 1'b1;
        exp_q.delete();
        rd(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
